// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp timer plus MSIP/SSIP bits on a Wishbone-classic slave.
// Latency: registered ack one cycle after acceptance; register updates visible on mem_* in the ack cycle.
// Backpressure: none beyond the handshake; a held strobe is accepted every other cycle.
module clint #(
    parameter int DATA_SIZE             = 32,
    parameter int CLOCK_CYCLES_PER_TICK = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [15:0]            wb_addr_i,
    input  logic [DATA_SIZE/8-1:0] wb_sel_i,
    input  logic [DATA_SIZE-1:0]   wb_dat_i,
    output logic [DATA_SIZE-1:0]   wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   mem_msip,
    output logic                   mem_ssip,
    output logic [63:0]            mem_mtime,
    output logic [63:0]            mem_mtimecmp
);

    localparam int SEL_W = DATA_SIZE / 8;
    localparam int PS_W  = (CLOCK_CYCLES_PER_TICK > 1) ? $clog2(CLOCK_CYCLES_PER_TICK) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLOCK_CYCLES_PER_TICK - 1);

    localparam logic [15:0] ALIGN_MASK = 16'(SEL_W - 1);
    localparam logic [15:0] HALF_BIT   = (DATA_SIZE == 32) ? 16'h0004 : 16'h0000;
    localparam logic [15:0] SIP_BASE   = 16'h0000;
    localparam logic [15:0] CMP_BASE   = 16'h4000;
    localparam logic [15:0] TIME_BASE  = 16'hBFF8;

    logic            accept;
    logic            aligned;
    logic            upper;
    logic [15:0]     base;
    logic            wr;
    logic            sip_we;
    logic            cmp_we;
    logic            time_we;
    logic [63:0]     bus_dat64;
    logic [7:0]      bus_sel8;
    logic [63:0]     bus_bmask;
    logic [63:0]     rd64;
    logic [DATA_SIZE-1:0] rd_word;
    logic [PS_W-1:0] prescaler;
    logic            tick;

    assign accept  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign aligned = (wb_addr_i & ALIGN_MASK) == 16'h0000;
    assign upper   = (wb_addr_i & HALF_BIT) != 16'h0000;
    assign base    = wb_addr_i & ~HALF_BIT;

    assign wr      = accept & wb_we_i & aligned;
    assign sip_we  = wr & (base == SIP_BASE);
    assign cmp_we  = wr & (base == CMP_BASE);
    assign time_we = wr & (base == TIME_BASE);

    // Every register is handled as a 64-bit view: a 32-bit bus word is steered onto
    // the half selected by address bit 2, so msip/ssip become bits 0 and 32 of one word.
    generate
        if (DATA_SIZE == 32) begin : g_bus32
            assign bus_dat64 = {wb_dat_i, wb_dat_i};
            assign bus_sel8  = upper ? {wb_sel_i, 4'b0000} : {4'b0000, wb_sel_i};
            assign rd_word   = upper ? rd64[63:32] : rd64[31:0];
        end else begin : g_bus64
            assign bus_dat64 = wb_dat_i;
            assign bus_sel8  = wb_sel_i;
            assign rd_word   = rd64;
        end
    endgenerate

    always_comb begin
        bus_bmask = '0;
        for (int i = 0; i < 8; i++) begin
            bus_bmask[8*i +: 8] = {8{bus_sel8[i]}};
        end
    end

    always_comb begin
        rd64 = '0;
        if (aligned) begin
            case (base)
                SIP_BASE:  rd64 = {31'b0, mem_ssip, 31'b0, mem_msip};
                CMP_BASE:  rd64 = mem_mtimecmp;
                TIME_BASE: rd64 = mem_mtime;
                default:   rd64 = '0;
            endcase
        end
    end

    assign tick = (prescaler == PS_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= accept;
            wb_dat_o <= (accept && !wb_we_i) ? rd_word : '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_msip <= 1'b0;
            mem_ssip <= 1'b0;
        end else begin
            if (sip_we && bus_sel8[0]) begin
                mem_msip <= bus_dat64[0];
            end
            if (sip_we && bus_sel8[4]) begin
                mem_ssip <= bus_dat64[32];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_mtimecmp <= '1;
        end else if (cmp_we) begin
            mem_mtimecmp <= (mem_mtimecmp & ~bus_bmask) | (bus_dat64 & bus_bmask);
        end
    end

    // A bus write to mtime overrides a coincident tick and restarts the prescaler.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_mtime <= '0;
            prescaler <= '0;
        end else if (time_we) begin
            mem_mtime <= (mem_mtime & ~bus_bmask) | (bus_dat64 & bus_bmask);
            prescaler <= '0;
        end else if (tick) begin
            mem_mtime <= mem_mtime + 64'd1;
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint (DATA_SIZE=32, two clocks per mtime tick).
module tb_clint;

    logic        clock;
    logic        reset;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [15:0] wb_addr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        mem_msip;
    logic        mem_ssip;
    logic [63:0] mem_mtime;
    logic [63:0] mem_mtimecmp;

    int errors = 0;
    int checks = 0;

    clint #(.DATA_SIZE(32), .CLOCK_CYCLES_PER_TICK(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .wb_cyc_i     (wb_cyc_i),
        .wb_stb_i     (wb_stb_i),
        .wb_we_i      (wb_we_i),
        .wb_addr_i    (wb_addr_i),
        .wb_sel_i     (wb_sel_i),
        .wb_dat_i     (wb_dat_i),
        .wb_dat_o     (wb_dat_o),
        .wb_ack_o     (wb_ack_o),
        .mem_msip     (mem_msip),
        .mem_ssip     (mem_ssip),
        .mem_mtime    (mem_mtime),
        .mem_mtimecmp (mem_mtimecmp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request and returns in its ack cycle (1 ns after the edge) with the bus idle.
    task automatic xfer(input logic we, input logic [15:0] addr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdat, output int waited);
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_we_i   = we;
        wb_addr_i = addr;
        wb_dat_i  = dat;
        wb_sel_i  = sel;
        waited    = 0;
        do begin
            @(posedge clock);
            #1;
            waited++;
        end while (!wb_ack_o && waited < 4);
        rdat = wb_dat_o;
        chk("ack_arrives", {63'b0, wb_ack_o}, 64'd1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          w;
        logic        ack_seen;
        logic [63:0] prev;
        logic [3:0]  ack_pat;

        reset     = 1'b0;
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        wb_addr_i = 16'h0;
        wb_sel_i  = 4'h0;
        wb_dat_i  = 32'h0;

        // Reset values
        #12;
        chk("rst_mtime", mem_mtime, 64'd0);
        chk("rst_mtimecmp", mem_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_msip", {63'b0, mem_msip}, 64'd0);
        chk("rst_ssip", {63'b0, mem_ssip}, 64'd0);
        chk("rst_ack", {63'b0, wb_ack_o}, 64'd0);
        chk("rst_dat", {32'b0, wb_dat_o}, 64'd0);

        // Ten cycles after release: five ticks, no spurious ack
        @(posedge clock);
        #1;
        reset = 1'b1;
        ack_seen = 1'b0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (wb_ack_o) ack_seen = 1'b1;
        end
        chk("tick_mtime5", mem_mtime, 64'd5);
        chk("tick_no_ack", {63'b0, ack_seen}, 64'd0);
        chk("tick_cmp_ones", mem_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);

        // Software interrupts
        xfer(1'b1, 16'h0000, 32'h1, 4'hF, rd, w);
        chk("msip_set", {63'b0, mem_msip}, 64'd1);
        chk("ssip_untouched", {63'b0, mem_ssip}, 64'd0);
        xfer(1'b1, 16'h0004, 32'h1, 4'hF, rd, w);
        chk("ssip_set", {63'b0, mem_ssip}, 64'd1);
        xfer(1'b0, 16'h0000, 32'h0, 4'hF, rd, w);
        chk("msip_read", {32'b0, rd}, 64'd1);
        xfer(1'b0, 16'h0004, 32'h0, 4'hF, rd, w);
        chk("ssip_read", {32'b0, rd}, 64'd1);
        xfer(1'b1, 16'h0000, 32'h0, 4'hF, rd, w);
        chk("msip_clear", {63'b0, mem_msip}, 64'd0);
        chk("ssip_kept", {63'b0, mem_ssip}, 64'd1);

        // Compare programming and MTIP crossing at mtime=16
        xfer(1'b1, 16'h4000, 32'h10, 4'hF, rd, w);
        xfer(1'b1, 16'h4004, 32'h0, 4'hF, rd, w);
        chk("cmp_0x10", mem_mtimecmp, 64'h10);
        xfer(1'b1, 16'hBFFC, 32'h0, 4'hF, rd, w);
        xfer(1'b1, 16'hBFF8, 32'h0, 4'hF, rd, w);
        chk("mtime_zeroed", mem_mtime, 64'd0);
        repeat (31) idle();
        chk("mtime_15", mem_mtime, 64'd15);
        chk("mtip_low", {63'b0, (mem_mtime >= mem_mtimecmp)}, 64'd0);
        idle();
        chk("mtime_16", mem_mtime, 64'd16);
        chk("mtip_high", {63'b0, (mem_mtime >= mem_mtimecmp)}, 64'd1);

        // Write colliding with a tick: find a tick, then accept on the following max-prescaler edge
        prev = mem_mtime;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (mem_mtime != prev) break;
        end
        chk("tick_found", {63'b0, (mem_mtime != prev)}, 64'd1);
        idle();
        xfer(1'b1, 16'hBFF8, 32'h100, 4'hF, rd, w);
        chk("collide_write_wins", mem_mtime, 64'h100);
        idle();
        chk("collide_hold", mem_mtime, 64'h100);
        idle();
        chk("collide_next_tick", mem_mtime, 64'h101);

        // Wrap from all ones
        xfer(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, rd, w);
        xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, w);
        chk("wrap_all_ones", mem_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        chk("wrap_hold", mem_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        chk("wrap_zero", mem_mtime, 64'd0);

        // Byte enables on both halves, readback, misaligned access
        xfer(1'b1, 16'h4000, 32'hAABB_CCDD, 4'b0010, rd, w);
        chk("sel_byte1", mem_mtimecmp, 64'h0000_0000_0000_CC10);
        xfer(1'b1, 16'h4004, 32'h1122_3344, 4'b1000, rd, w);
        chk("sel_byte7", mem_mtimecmp, 64'h1100_0000_0000_CC10);
        xfer(1'b0, 16'h4000, 32'h0, 4'hF, rd, w);
        chk("cmp_lo_read", {32'b0, rd}, 64'h0000_CC10);
        xfer(1'b0, 16'h4004, 32'h0, 4'hF, rd, w);
        chk("cmp_hi_read", {32'b0, rd}, 64'h1100_0000);
        xfer(1'b1, 16'h4002, 32'hFFFF_FFFF, 4'hF, rd, w);
        chk("misaligned_write_ignored", mem_mtimecmp, 64'h1100_0000_0000_CC10);
        xfer(1'b0, 16'h4002, 32'h0, 4'hF, rd, w);
        chk("misaligned_read_zero", {32'b0, rd}, 64'd0);

        // Unmapped read
        idle();
        xfer(1'b0, 16'h0100, 32'h0, 4'hF, rd, w);
        chk("unmapped_latency", 64'(w), 64'd1);
        chk("unmapped_data", {32'b0, rd}, 64'd0);
        idle();
        chk("dat_zero_after_ack", {32'b0, wb_dat_o}, 64'd0);

        // Strobe held for four cycles: ack in cycles 2 and 4 only
        ack_pat   = 4'b1010;
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_we_i   = 1'b0;
        wb_addr_i = 16'h0000;
        chk("hold_cycle1", {63'b0, wb_ack_o}, 64'd0);
        for (int c = 2; c <= 4; c++) begin
            idle();
            chk($sformatf("hold_cycle%0d", c), {63'b0, wb_ack_o}, {63'b0, ack_pat[c-1]});
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        idle();
        chk("hold_cycle5", {63'b0, wb_ack_o}, 64'd0);

        // Reset while a request is pending: immediate clear, no ack
        idle();
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_addr_i = 16'h0004;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("async_rst_mtime", mem_mtime, 64'd0);
        chk("async_rst_cmp", mem_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("async_rst_ssip", {63'b0, mem_ssip}, 64'd0);
        ack_seen = 1'b0;
        @(posedge clock);
        #1;
        if (wb_ack_o) ack_seen = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        reset    = 1'b1;
        repeat (3) begin
            idle();
            if (wb_ack_o) ack_seen = 1'b1;
        end
        chk("rst_mid_no_ack", {63'b0, ack_seen}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clint.md
# clint

Core-local interruptor: memory-mapped timer and software-interrupt block that sits directly upstream of the CSR unit. It owns the 64-bit `mtime` counter, the 64-bit `mtimecmp` compare register and the MSIP/SSIP bits, exposes them on a Wishbone-classic slave port, and drives the CSR unit's `mem_mtime`, `mem_mtimecmp`, `mem_msip` and `mem_ssip` inputs. The CSR unit derives MTIP itself as `mem_mtime >= mem_mtimecmp`.

## Interface
- `DATA_SIZE`, 32: bus data width, 32 or 64.
- `CLOCK_CYCLES_PER_TICK`, 2: clock cycles per `mtime` increment, ≥1; value 1 means increment every cycle.
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wb_cyc_i` in 1: bus cycle valid.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: 1 = write.
- `wb_addr_i` in 16: byte address, offset within block.
- `wb_sel_i` in DATA_SIZE/8: byte enables.
- `wb_dat_i` in DATA_SIZE: write data.
- `wb_dat_o` out DATA_SIZE: read data, valid while `wb_ack_o`=1.
- `wb_ack_o` out 1: single-cycle acknowledge.
- `mem_msip` out 1: machine software interrupt pending.
- `mem_ssip` out 1: supervisor software interrupt pending.
- `mem_mtime` out 64: current `mtime`.
- `mem_mtimecmp` out 64: current `mtimecmp`.

## Operation
- Register map (byte offsets):
  - 0x0000 msip (bit 0 only).
  - 0x0004 ssip (bit 0 only).
  - 0x4000 mtimecmp.
  - 0xBFF8 mtime.
- DATA_SIZE=32: each 64-bit register is split into two words, low half at the base offset, high half at base+4.
- DATA_SIZE=64: each 64-bit register is one word at its base offset. msip is at 0x0000 bits [0] and ssip at 0x0000 bits [32]; offset 0x0004 is unmapped.
- Unmapped or misaligned address (not a multiple of DATA_SIZE/8): acknowledged normally, reads return 0, writes are ignored. No error signalling.
- Writes honour `wb_sel_i` per byte. msip/ssip take bit 0 of their byte lane; their other bits read 0.
- Prescaler counts 0 .. CLOCK_CYCLES_PER_TICK-1. On the cycle it holds its maximum value, `mtime` increments by 1 and the prescaler returns to 0. `mtime` wraps from 2^64-1 to 0.
- Write to any part of `mtime`: the written bytes take the bus value, unwritten bytes keep their current (non-incremented) value, and the prescaler clears to 0. The bus write wins over a same-cycle tick.
- Reset values:
  - `mtime` = 0 and prescaler = 0.
  - `mtimecmp` = all ones, so MTIP is not raised out of reset.
  - `mem_msip` = 0 and `mem_ssip` = 0.
  - `wb_ack_o` = 0 and `wb_dat_o` = 0.

## Timing
- Request accepted on a rising edge where `wb_cyc_i & wb_stb_i & !wb_ack_o`.
- `wb_ack_o` is registered: high for exactly one cycle, in the cycle after acceptance. It is always low in the cycle following an ack, so back-to-back requests are acknowledged every other cycle.
- Write data is sampled at acceptance. The register update is visible on the `mem_*` outputs in the same cycle `wb_ack_o` is high.
- Read data is captured at acceptance and held in `wb_dat_o` during the ack cycle; `wb_dat_o` is 0 otherwise. An `mtime` read returns the value present at the acceptance edge.
- All `mem_*` outputs come directly from flops; there is no combinational path from the bus inputs.
- DATA_SIZE=32, 64-bit registers: there is no atomicity between halves. Software handles carry from low to high.
- Dropping `wb_cyc_i` while the ack is pending: the ack still pulses once and the write has still taken effect.
- Reset asserted mid-transaction: all state returns to its reset value immediately and asynchronously; no ack is produced.

## Test plan
- Reset and tick: release reset with CLOCK_CYCLES_PER_TICK=2 and run 10 cycles -> `mem_mtime`=5, `mem_mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, `mem_msip`=0, `mem_ssip`=0, `wb_ack_o`=0 throughout.
- Software interrupts: write 0x1 to 0x0000, then 0x1 to 0x0004 (DATA_SIZE=32) -> `mem_msip`=1 in the first ack cycle, `mem_ssip`=1 in the second ack cycle; read 0x0000 -> `wb_dat_o`=0x1. Write 0x0 to 0x0000 -> `mem_msip`=0.
- Compare programming: write 0x0000_0010 to 0x4000 and 0x0 to 0x4004 -> `mem_mtimecmp`=0x10; the CSR-side comparison `mem_mtime >= mem_mtimecmp` becomes true once `mtime` reaches 16.
- Write/tick collision: write 0x100 to 0xBFF8 on the cycle the prescaler is at its maximum -> `mem_mtime` low word=0x100 (not 0x101), then increments to 0x101 CLOCK_CYCLES_PER_TICK cycles later.
- Wrap and byte enables: set `mtime`=0xFFFF_FFFF_FFFF_FFFF -> next tick gives 0. Write 0xAABBCCDD to 0x4000 with `wb_sel_i`=4'b0010 -> only byte 1 of `mtimecmp` becomes 0xCC.
- Unmapped access and handshake: read 0x0100 -> ack after 1 cycle, data 0. Hold `wb_stb_i` high for 4 cycles -> `wb_ack_o` pulses in cycles 2 and 4 only. Assert reset while ack is pending -> ack never appears.
